// File: rtl/demux_stream.sv
// Registered packet demultiplexer: one valid/ready input stream steered per packet
// to one of 2**sel_bits lanes. Optional broadcast mode is enabled with DEMUX_BCAST_EN.
module demux_stream #(
  parameter int data_bits = 8,
  parameter int sel_bits  = 2
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [data_bits-1:0]                      data_in,
  input  logic                                      in_valid,
  input  logic                                      in_last,
  input  logic [sel_bits-1:0]                       sel,
  output logic                                      in_ready,
  output logic [(2**sel_bits)-1:0][data_bits-1:0]   data_out,
  output logic [(2**sel_bits)-1:0]                  out_valid,
  output logic [(2**sel_bits)-1:0]                  out_last,
  input  logic [(2**sel_bits)-1:0]                  out_ready
`ifdef DEMUX_BCAST_EN
  ,
  input  logic                                      bcast
`endif
);

  localparam int lanes = 2**sel_bits;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [sel_bits-1:0]  locked_sel;
  logic [sel_bits-1:0]  locked_sel_nxt;
  logic [sel_bits-1:0]  target;
  logic [lanes-1:0]     target_hot;
  logic [lanes-1:0]     lane_free;
  logic [lanes-1:0]     load;
  logic                 bcast_act;
  logic                 accept;

`ifdef DEMUX_BCAST_EN
  logic locked_bcast;
  logic locked_bcast_nxt;

  assign bcast_act = (state == IDLE) ? bcast : locked_bcast;
`else
  assign bcast_act = 1'b0;
`endif

  // The target lane follows sel only until the first beat locks it for the packet.
  always_comb begin
    target        = (state == IDLE) ? sel : locked_sel;
    target_hot    = '0;
    target_hot[target] = 1'b1;
    lane_free     = ~out_valid | out_ready;
    if (!rst_n) begin
      in_ready = 1'b0;
    end else if (bcast_act) begin
      in_ready = &lane_free;
    end else begin
      in_ready = lane_free[target];
    end
    accept = in_valid && in_ready;
    load   = {lanes{accept}} & ({lanes{bcast_act}} | target_hot);
  end

  always_comb begin
    state_nxt      = state;
    locked_sel_nxt = locked_sel;
`ifdef DEMUX_BCAST_EN
    locked_bcast_nxt = locked_bcast;
`endif
    case (state)
      IDLE: begin
        if (accept && !in_last) begin
          state_nxt      = BURST;
          locked_sel_nxt = sel;
`ifdef DEMUX_BCAST_EN
          locked_bcast_nxt = bcast;
`endif
        end
      end
      BURST: begin
        if (accept && in_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      locked_sel <= '0;
`ifdef DEMUX_BCAST_EN
      locked_bcast <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      locked_sel <= locked_sel_nxt;
`ifdef DEMUX_BCAST_EN
      locked_bcast <= locked_bcast_nxt;
`endif
    end
  end

  // A load into a lane takes priority over that lane draining in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out  <= '0;
      out_valid <= '0;
      out_last  <= '0;
    end else begin
      for (int k = 0; k < lanes; k++) begin
        if (load[k]) begin
          data_out[k]  <= data_in;
          out_last[k]  <= in_last;
          out_valid[k] <= 1'b1;
        end else if (out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
    end
  end

endmodule
